// File: rtl/pw_lock_pkg.sv
// Shared types and helpers for the button password lock: state encoding,
// digit geometry and one-hot button decoding.
package pw_lock_pkg;

  localparam int DIGIT_W   = 2;
  localparam int DIGIT_CNT = 4;
  localparam int PW_W      = DIGIT_W * DIGIT_CNT;

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_CHANGE  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  function automatic logic is_onehot4(input logic [3:0] s);
    return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
  endfunction

  // Button 4'b1000 is digit 0, 4'b0001 is digit 3.
  function automatic logic [DIGIT_W-1:0] decode_onehot(input logic [3:0] s);
    case (s)
      4'b1000: return 2'd0;
      4'b0100: return 2'd1;
      4'b0010: return 2'd2;
      4'b0001: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  // Digit 0 occupies the top bits of the password word.
  function automatic logic [DIGIT_W-1:0] get_digit(input logic [PW_W-1:0] pw,
                                                   input logic [1:0] idx);
    case (idx)
      2'd0:    return pw[7:6];
      2'd1:    return pw[5:4];
      2'd2:    return pw[3:2];
      default: return pw[1:0];
    endcase
  endfunction

  function automatic logic [PW_W-1:0] set_digit(input logic [PW_W-1:0] pw,
                                                input logic [1:0] idx,
                                                input logic [DIGIT_W-1:0] d);
    logic [PW_W-1:0] r;
    r = pw;
    case (idx)
      2'd0:    r[7:6] = d;
      2'd1:    r[5:4] = d;
      2'd2:    r[3:2] = d;
      default: r[1:0] = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pw_lock_ctrl_key_press_det.sv
// Turns raw button levels into single-cycle press events; a press counts only
// when exactly one button goes down from an all-released previous sample.
module key_press_det
  import pw_lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         s,
  output logic               press_vld,
  output logic [DIGIT_W-1:0] press_digit
);

  logic [3:0] s_q_r;

  // Previous button sample, used to reject held buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q_r <= 4'd0;
    end else begin
      s_q_r <= s;
    end
  end

  // Event qualification and digit decode.
  always_comb begin
    press_vld   = is_onehot4(s) && (s_q_r == 4'd0);
    press_digit = decode_onehot(s);
  end

endmodule

// File: rtl/pw_lock_ctrl.sv
// Password lock sequencer: digit entry and compare, timed unlock, failed-attempt
// lockout and in-field password change.
module pw_lock_ctrl
  import pw_lock_pkg::*;
#(
  parameter logic [7:0] INIT_PW     = 8'b00_01_10_11,
  parameter int         MAX_FAIL    = 3,
  parameter int         OPEN_CYCLES = 16,
  parameter int         LOCK_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] s,
  input  logic       chg_req,
  output logic       unlocked,
  output logic       locked_out,
  output logic       chg_mode,
  output logic [1:0] digit_idx,
  output logic [2:0] fail_cnt
);

  localparam int TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam logic [TMR_W-1:0] OPEN_LOAD = TMR_W'(OPEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LOAD = TMR_W'(LOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO  = TMR_W'(0);
  localparam logic [2:0]       MAX_FAIL_C = 3'(MAX_FAIL);

  state_t               state_r;
  logic [TMR_W-1:0]     timer_r;
  logic [PW_W-1:0]      pw_r;
  logic [PW_W-1:0]      shadow_r;
  logic                 mismatch_r;
  logic [1:0]           digit_idx_r;
  logic [2:0]           fail_cnt_r;
  logic                 unlocked_r;
  logic                 locked_out_r;
  logic                 chg_mode_r;

  logic                 press_vld_s;
  logic [DIGIT_W-1:0]   press_digit_s;
  logic                 entry_miss_s;
  logic [2:0]           fail_inc_s;
  logic [PW_W-1:0]      new_pw_s;

  key_press_det u_key_press_det (
    .clk         (clk),
    .rst_n       (rst_n),
    .s           (s),
    .press_vld   (press_vld_s),
    .press_digit (press_digit_s)
  );

  // Per-press helpers: running mismatch, next fail count, shadow with new digit.
  always_comb begin
    entry_miss_s = mismatch_r | (press_digit_s != get_digit(pw_r, digit_idx_r));
    fail_inc_s   = fail_cnt_r + 3'd1;
    new_pw_s     = set_digit(shadow_r, digit_idx_r, press_digit_s);
  end

  // Lock FSM with timer, counters, password storage and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_ENTRY;
      timer_r      <= TMR_ZERO;
      pw_r         <= INIT_PW;
      shadow_r     <= INIT_PW;
      mismatch_r   <= 1'b0;
      digit_idx_r  <= 2'd0;
      fail_cnt_r   <= 3'd0;
      unlocked_r   <= 1'b0;
      locked_out_r <= 1'b0;
      chg_mode_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_ENTRY: begin
          if (press_vld_s) begin
            if (digit_idx_r == 2'd3) begin
              digit_idx_r <= 2'd0;
              mismatch_r  <= 1'b0;
              if (!entry_miss_s) begin
                state_r    <= ST_OPEN;
                fail_cnt_r <= 3'd0;
                timer_r    <= OPEN_LOAD;
                unlocked_r <= 1'b1;
              end else if (fail_inc_s == MAX_FAIL_C) begin
                state_r      <= ST_LOCKOUT;
                fail_cnt_r   <= MAX_FAIL_C;
                timer_r      <= LOCK_LOAD;
                locked_out_r <= 1'b1;
              end else begin
                fail_cnt_r <= fail_inc_s;
              end
            end else begin
              digit_idx_r <= digit_idx_r + 2'd1;
              mismatch_r  <= entry_miss_s;
            end
          end
        end
        // Change request wins over expiry; the inactivity timer restarts here.
        ST_OPEN: begin
          if (chg_req) begin
            state_r     <= ST_CHANGE;
            unlocked_r  <= 1'b0;
            chg_mode_r  <= 1'b1;
            timer_r     <= OPEN_LOAD;
            digit_idx_r <= 2'd0;
            shadow_r    <= pw_r;
          end else if (timer_r == TMR_ZERO) begin
            state_r    <= ST_ENTRY;
            unlocked_r <= 1'b0;
          end else begin
            timer_r <= timer_r - TMR_ONE;
          end
        end
        ST_CHANGE: begin
          if (press_vld_s) begin
            shadow_r <= new_pw_s;
            timer_r  <= OPEN_LOAD;
            if (digit_idx_r == 2'd3) begin
              pw_r        <= new_pw_s;
              state_r     <= ST_ENTRY;
              chg_mode_r  <= 1'b0;
              digit_idx_r <= 2'd0;
            end else begin
              digit_idx_r <= digit_idx_r + 2'd1;
            end
          end else if (timer_r == TMR_ZERO) begin
            state_r     <= ST_ENTRY;
            chg_mode_r  <= 1'b0;
            digit_idx_r <= 2'd0;
          end else begin
            timer_r <= timer_r - TMR_ONE;
          end
        end
        ST_LOCKOUT: begin
          if (timer_r == TMR_ZERO) begin
            state_r      <= ST_ENTRY;
            locked_out_r <= 1'b0;
            fail_cnt_r   <= 3'd0;
          end else begin
            timer_r <= timer_r - TMR_ONE;
          end
        end
        default: begin
          state_r      <= ST_ENTRY;
          unlocked_r   <= 1'b0;
          locked_out_r <= 1'b0;
          chg_mode_r   <= 1'b0;
          digit_idx_r  <= 2'd0;
          mismatch_r   <= 1'b0;
        end
      endcase
    end
  end

  assign unlocked   = unlocked_r;
  assign locked_out = locked_out_r;
  assign chg_mode   = chg_mode_r;
  assign digit_idx  = digit_idx_r;
  assign fail_cnt   = fail_cnt_r;

endmodule

// File: tb/tb_pw_lock_ctrl.sv
// Directed bench for pw_lock_ctrl: expected status words and durations are
// queued as stimulus is driven and compared when the DUT responds.
module tb_pw_lock_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] s;
  logic       chg_req;
  logic       unlocked;
  logic       locked_out;
  logic       chg_mode;
  logic [1:0] digit_idx;
  logic [2:0] fail_cnt;

  int checks;
  int failures;

  typedef struct {
    string tag;
    int    exp;
  } sb_t;

  sb_t sb_q[$];

  pw_lock_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s          (s),
    .chg_req    (chg_req),
    .unlocked   (unlocked),
    .locked_out (locked_out),
    .chg_mode   (chg_mode),
    .digit_idx  (digit_idx),
    .fail_cnt   (fail_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int st(input int u, input int l, input int c, input int idx, input int fc);
    return (u << 7) | (l << 6) | (c << 5) | (idx << 3) | fc;
  endfunction

  function automatic int obs();
    return int'({unlocked, locked_out, chg_mode, digit_idx, fail_cnt});
  endfunction

  function automatic logic [3:0] onehot(input int d);
    logic [3:0] v;
    v = 4'b1000;
    return v >> d;
  endfunction

  function automatic logic sel(input int w);
    case (w)
      0:       return unlocked;
      1:       return locked_out;
      default: return chg_mode;
    endcase
  endfunction

  task automatic expect_push(input string tag, input int exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic check_pop(input int observed);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d", observed);
    end else begin
      e = sb_q.pop_front();
      assert (observed === e.exp) else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, observed, e.exp);
      end
    end
  endtask

  // One press with release; status is compared on the negedge after the sample.
  task automatic press(input int d, input int exp, input string tag);
    @(negedge clk);
    s = onehot(d);
    expect_push(tag, exp);
    @(negedge clk);
    s = 4'd0;
    check_pop(obs());
  endtask

  task automatic enter4(input int d0, input int d1, input int d2, input int d3,
                        input int fc, input int final_exp, input string tag);
    press(d0, st(0, 0, 0, 1, fc), {tag, "_d0"});
    press(d1, st(0, 0, 0, 2, fc), {tag, "_d1"});
    press(d2, st(0, 0, 0, 3, fc), {tag, "_d2"});
    press(d3, final_exp, {tag, "_d3"});
  endtask

  task automatic measure(input int which, output int cnt);
    cnt = 0;
    while (sel(which) && cnt < 500) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic pulse_chg(input string tag);
    @(negedge clk);
    chg_req = 1'b1;
    expect_push(tag, st(0, 0, 1, 0, 0));
    @(negedge clk);
    chg_req = 1'b0;
    check_pop(obs());
  endtask

  initial begin
    int cnt;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    s        = 4'd0;
    chg_req  = 1'b0;

    repeat (3) @(negedge clk);
    expect_push("reset_state", st(0, 0, 0, 0, 0));
    check_pop(obs());
    rst_n = 1'b1;

    // Default password unlocks for exactly OPEN_CYCLES.
    enter4(0, 1, 2, 3, 0, st(1, 0, 0, 0, 0), "unlock_default");
    expect_push("open_duration", 16);
    measure(0, cnt);
    check_pop(cnt);
    expect_push("after_open", st(0, 0, 0, 0, 0));
    check_pop(obs());

    // Three bad entries lead to lockout.
    enter4(0, 1, 2, 2, 0, st(0, 0, 0, 0, 1), "fail1");
    enter4(0, 1, 2, 2, 1, st(0, 0, 0, 0, 2), "fail2");
    enter4(0, 1, 2, 2, 2, st(0, 1, 0, 0, 3), "fail3_lockout");

    // Lockout duration with presses and change requests thrown at it.
    expect_push("lockout_duration", 64);
    cnt = 0;
    while (locked_out && cnt < 500) begin
      s       = ((cnt % 4) == 1) ? 4'b0100 : 4'b0000;
      chg_req = ((cnt % 8) == 3);
      cnt++;
      @(negedge clk);
    end
    s       = 4'd0;
    chg_req = 1'b0;
    check_pop(cnt);
    expect_push("after_lockout", st(0, 0, 0, 0, 0));
    check_pop(obs());

    // Held button produces one event; multi-hot produces none.
    @(negedge clk);
    s = 4'b0100;
    repeat (10) @(negedge clk);
    expect_push("held_one_event", st(0, 0, 0, 1, 0));
    check_pop(obs());
    s = 4'd0;
    @(negedge clk);
    s = 4'b0110;
    @(negedge clk);
    s = 4'd0;
    @(negedge clk);
    expect_push("multihot_ignored", st(0, 0, 0, 1, 0));
    check_pop(obs());
    press(0, st(0, 0, 0, 2, 0), "held_seq_d1");
    press(0, st(0, 0, 0, 3, 0), "held_seq_d2");
    press(0, st(0, 0, 0, 0, 1), "held_seq_fail");

    // Change aborted by inactivity leaves the old password in place.
    enter4(0, 1, 2, 3, 1, st(1, 0, 0, 0, 0), "unlock_before_chg");
    pulse_chg("chg_enter1");
    press(2, st(0, 0, 1, 1, 0), "chg_abort_d0");
    press(2, st(0, 0, 1, 2, 0), "chg_abort_d1");
    expect_push("chg_timeout", 16);
    measure(2, cnt);
    check_pop(cnt);
    expect_push("after_chg_timeout", st(0, 0, 0, 0, 0));
    check_pop(obs());
    enter4(0, 1, 2, 3, 0, st(1, 0, 0, 0, 0), "old_pw_kept");

    // Full change to 3,3,0,1.
    pulse_chg("chg_enter2");
    press(3, st(0, 0, 1, 1, 0), "chg_d0");
    press(3, st(0, 0, 1, 2, 0), "chg_d1");
    press(0, st(0, 0, 1, 3, 0), "chg_d2");
    press(1, st(0, 0, 0, 0, 0), "chg_done");
    enter4(0, 1, 2, 3, 0, st(0, 0, 0, 0, 1), "old_pw_rejected");
    enter4(3, 3, 0, 1, 1, st(1, 0, 0, 0, 0), "new_pw_unlocks");

    // Reset during change restores the initial password.
    pulse_chg("chg_enter3");
    press(0, st(0, 0, 1, 1, 0), "rst_chg_d0");
    press(0, st(0, 0, 1, 2, 0), "rst_chg_d1");
    press(0, st(0, 0, 1, 3, 0), "rst_chg_d2");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    expect_push("async_reset", st(0, 0, 0, 0, 0));
    check_pop(obs());
    @(negedge clk);
    rst_n = 1'b1;
    enter4(0, 1, 2, 3, 0, st(1, 0, 0, 0, 0), "init_pw_restored");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pw_lock_ctrl.md
# pw_lock_ctrl

Sequencing controller for the 4-digit, 2-bit-per-digit button password lock. Turns raw one-hot button levels into single press events, then compares the four-digit entry against a stored password. Drives timed unlock, failed-attempt lockout and in-field password change. Sits between the front-panel buttons and the door/indicator outputs.

## Interface
- `INIT_PW`, 8'b00_01_10_11: password loaded on reset; digit 0 in [7:6], digit 3 in [1:0].
- `MAX_FAIL`, 3: consecutive failed entries that trigger lockout (1..7).
- `OPEN_CYCLES`, 16: unlock hold time, and CHANGE inactivity timeout, in clk cycles (≥2).
- `LOCK_CYCLES`, 64: lockout duration in clk cycles (≥2).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s`  in  4  button levels, synchronous to clk. 4'b1000=digit 0, 0100=1, 0010=2, 0001=3.
- `chg_req`  in  1  password-change request, level-sampled; honoured only in OPEN.
- `unlocked`  out  1  high while in OPEN.
- `locked_out`  out  1  high while in LOCKOUT.
- `chg_mode`  out  1  high while in CHANGE.
- `digit_idx`  out  2  digits accepted so far in the current ENTRY/CHANGE sequence.
- `fail_cnt`  out  3  consecutive failed entries.

## Operation
- Press event: `s` is exactly one-hot AND registered `s_q` == 4'b0000. Any other `s` value (zero, multi-hot, held) is not an event. A held button yields one event, and the button must be released before the next event.
- States: ENTRY, OPEN, CHANGE, LOCKOUT. Reset state is ENTRY.
- Reset values: `pw_reg`=INIT_PW, all outputs 0, `digit_idx`=0, `fail_cnt`=0, mismatch flag=0, timer=0.
- ENTRY, on each event:
  - compare the decoded digit with `pw_reg` digit[`digit_idx`], OR the result into the mismatch flag;
  - increment `digit_idx`.
- ENTRY, 4th event (`digit_idx`==3), all 4 digits always collected, no early reject:
  - match → OPEN, `fail_cnt`←0;
  - mismatch and `fail_cnt`+1 == MAX_FAIL → LOCKOUT, `fail_cnt`←MAX_FAIL;
  - otherwise `fail_cnt`++ and stay in ENTRY.
  - In every case `digit_idx`←0 and mismatch←0.
- OPEN:
  - timer loaded with OPEN_CYCLES-1 on entry and decremented each cycle;
  - press events ignored;
  - `chg_req`=1 → CHANGE (takes priority over timer expiry in the same cycle);
  - timer==0 → ENTRY.
- CHANGE:
  - each event shifts the digit into shadow register position `digit_idx` and reloads the timer with OPEN_CYCLES-1;
  - 4th event → `pw_reg`←shadow, then ENTRY;
  - timer==0 with no 4th event → ENTRY, `pw_reg` unchanged, shadow discarded;
  - `digit_idx` resets on exit.
- LOCKOUT:
  - timer loaded with LOCK_CYCLES-1;
  - events and `chg_req` ignored;
  - timer==0 → ENTRY, `fail_cnt`←0.
- `rst_n` low mid-sequence (including mid-CHANGE) restores INIT_PW and aborts everything immediately.

## Timing
- All outputs are registered; no combinational input→output path.
- An event sampled at edge N updates `digit_idx` at edge N.
- When the event at edge N is the 4th, the state change and `unlocked`/`locked_out`/`chg_mode` are visible from edge N onward, i.e. in the cycle after the 4th press is sampled.
- `unlocked` is high for exactly OPEN_CYCLES cycles; `locked_out` is high for exactly LOCK_CYCLES cycles.
- Event on the same edge as a state exit from OPEN/LOCKOUT: ignored. Events are counted only while already in ENTRY/CHANGE.
- Timer width is $clog2(max(OPEN_CYCLES, LOCK_CYCLES)).

## Structure
- Package `pw_lock_pkg`:
  - state encoding (ENTRY=2'd0, OPEN=1, CHANGE=2, LOCKOUT=3);
  - one-hot→digit decode function;
  - digit width constant (2) and digit count constant (4).
- Sub-module `key_press_det`: registers `s`, outputs `press_vld` and `press_digit[1:0]`.
- FSM, timer, `fail_cnt`, `pw_reg` and shadow register live in the top module.

## Test plan
- Defaults, presses 0,1,2,3 (each 1000/0100/0010/0001 with a release between) → `unlocked`=1 for exactly 16 cycles, then `digit_idx`=0 and state ENTRY.
- Presses 0,1,2,2 → `unlocked` stays 0 and `fail_cnt`=1. Repeat twice more → `locked_out`=1 for 64 cycles, presses during lockout are ignored, then `fail_cnt`=0.
- Button 0100 held 10 cycles → `digit_idx` advances by exactly 1. `s`=4'b0110 → no change.
- Unlock, pulse `chg_req`, press 3,3,0,1 → `chg_mode` falls, state ENTRY. Then 0,1,2,3 → fails; 3,3,0,1 → `unlocked`=1.
- Enter CHANGE, press 2 digits, idle 16 cycles → back to ENTRY, and the old password 0,1,2,3 still unlocks.
- Assert `rst_n`=0 during CHANGE after 3 digits → all outputs 0 immediately. After release, 0,1,2,3 unlocks.
